msrv32_load_unit: RTL and testbench

- AHB-Lite read-side counterpart of the store path in the msrv32 pipeline.
- Issues word-aligned read address phases for LB/LH/LW/LBU/LHU.
- Tracks each transfer into its data phase and handles wait states and error responses.
- Extracts the addressed byte or halfword from HRDATA, sign- or zero-extends it, and returns a registered 32-bit result with a one-cycle valid pulse to writeback.

---
 rtl/msrv32_load_unit.sv | 115 +++++++++++
 tb/tb_msrv32_load_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/msrv32_load_unit.sv
// msrv32 load unit: AHB-Lite read master for LB/LH/LW/LBU/LHU.
// It issues a word-aligned address phase, follows the transfer through its
// data phase (wait states, error responses), then extracts and extends the
// addressed byte or halfword into a registered result with a valid pulse.
module msrv32_load_unit #(
  parameter int unsigned PIPELINED = 1
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        mem_rd_req_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] iadder_in,
  input  logic        ahb_ready_in,
  input  logic        ahb_resp_in,
  input  logic [31:0] ahb_rdata_in,
  output logic [31:0] d_addr_out,
  output logic [1:0]  ahb_htrans_out,
  output logic [2:0]  ahb_hsize_out,
  output logic [31:0] lu_output_out,
  output logic        load_valid_out,
  output logic        load_err_out,
  output logic        misaligned_out,
  output logic        stall_out
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] DATA = 1'b1;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  logic [0:0] state;
  logic [2:0] funct3_q;   // load type of the transfer in its data phase
  logic [1:0] offset_q;   // byte offset of the transfer in its data phase

  logic misaligned;
  logic accept;
  logic data_done;

  // Pick the addressed lane out of the read word and sign/zero-extend it.
  function automatic logic [31:0] extract(input logic [31:0] word,
                                          input logic [2:0]  f3,
                                          input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b100:  extract = {24'h000000, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b101:  extract = {16'h0000, h};
      default: extract = word;  // LW and undefined codes return the whole word
    endcase
  endfunction

  // Halfwords need an even address, words a 4-byte aligned one.
  assign misaligned = mem_rd_req_in &&
                      (((funct3_in[1:0] == 2'b01) && iadder_in[0]) ||
                       ((funct3_in == 3'b010) && (iadder_in[1:0] != 2'b00)));

  // A new address phase may start from IDLE, or overlap a data phase when pipelined.
  assign accept = !ms_riscv32_mp_rst_in && mem_rd_req_in && ahb_ready_in && !misaligned &&
                  ((state == IDLE) || ((PIPELINED != 0) && (state == DATA)));

  assign data_done = (state == DATA) && ahb_ready_in;

  assign d_addr_out     = {iadder_in[31:2], 2'b00};
  assign ahb_htrans_out = accept ? HTRANS_NONSEQ : HTRANS_IDLE;

  assign stall_out = !ms_riscv32_mp_rst_in &&
                     (((state == DATA) && !ahb_ready_in) ||
                      (mem_rd_req_in && !ahb_ready_in && !misaligned));

  // Transfer size follows the access width encoded in funct3[1:0].
  always_comb begin
    // NOTE: default assignment first so every path drives the output and no latch is inferred.
    ahb_hsize_out = 3'b010;
    case (funct3_in[1:0])
      2'b00:   ahb_hsize_out = 3'b000;
      2'b01:   ahb_hsize_out = 3'b001;
      default: ahb_hsize_out = 3'b010;
    endcase
  end

  // Phase tracking, data-phase capture, result register and status pulses.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state          <= IDLE;
      funct3_q       <= 3'b000;
      offset_q       <= 2'b00;
      lu_output_out  <= 32'h0000_0000;
      load_valid_out <= 1'b0;
      load_err_out   <= 1'b0;
      misaligned_out <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      load_valid_out <= data_done && !ahb_resp_in;
      load_err_out   <= data_done && ahb_resp_in;
      misaligned_out <= misaligned && ahb_ready_in;

      if (data_done && !ahb_resp_in)
        lu_output_out <= extract(ahb_rdata_in, funct3_q, offset_q);

      if (accept) begin
        state    <= DATA;
        funct3_q <= funct3_in;
        offset_q <= iadder_in[1:0];
      end else if (data_done) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_msrv32_load_unit.sv
// Directed self-checking bench for msrv32_load_unit (PIPELINED = 1).
// Inputs change 1 time unit after the rising edge; outputs are compared
// a further time unit later, well away from the next edge.
module tb_msrv32_load_unit;

  logic        clk;
  logic        rst;
  logic        req;
  logic [2:0]  funct3;
  logic [31:0] iadder;
  logic        ready;
  logic        resp;
  logic [31:0] rdata;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] lu_out;
  logic        valid;
  logic        err;
  logic        mis;
  logic        stall;

  int n_checks = 0;
  int n_errors = 0;

  msrv32_load_unit #(.PIPELINED(1)) dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .mem_rd_req_in        (req),
    .funct3_in            (funct3),
    .iadder_in            (iadder),
    .ahb_ready_in         (ready),
    .ahb_resp_in          (resp),
    .ahb_rdata_in         (rdata),
    .d_addr_out           (haddr),
    .ahb_htrans_out       (htrans),
    .ahb_hsize_out        (hsize),
    .lu_output_out        (lu_out),
    .load_valid_out       (valid),
    .load_err_out         (err),
    .misaligned_out       (mis),
    .stall_out            (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req    = 1'b0;
    funct3 = 3'b000;
    iadder = 32'h0;
    ready  = 1'b1;
    resp   = 1'b0;
  endtask

  // One isolated load: address phase, optional wait states, data phase, result check.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] word, input int waits, input logic [31:0] exp);
    req = 1'b1; funct3 = f3; iadder = addr; ready = 1'b1; resp = 1'b0;
    #1;
    check({tag, " htrans"}, 32'(htrans), 32'h2);
    check({tag, " haddr"}, haddr, {addr[31:2], 2'b00});
    tick();
    req = 1'b0;
    for (int w = 0; w < waits; w++) begin
      ready = 1'b0;
      #1;
      check({tag, " wait stall"}, 32'(stall), 32'h1);
      check({tag, " wait htrans"}, 32'(htrans), 32'h0);
      tick();
      check({tag, " wait no valid"}, 32'(valid), 32'h0);
    end
    ready = 1'b1; rdata = word;
    #1;
    check({tag, " data stall"}, 32'(stall), 32'h0);
    tick();
    check({tag, " valid"}, 32'(valid), 32'h1);
    check({tag, " result"}, lu_out, exp);
    check({tag, " no err"}, 32'(err), 32'h0);
    idle_inputs();
    tick();
    check({tag, " valid one cycle"}, 32'(valid), 32'h0);
    check({tag, " result held"}, lu_out, exp);
  endtask

  // Misaligned request: no address phase, one misaligned pulse, result untouched.
  task automatic do_misaligned(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] held);
    req = 1'b1; funct3 = f3; iadder = addr; ready = 1'b1; resp = 1'b0;
    #1;
    check({tag, " htrans"}, 32'(htrans), 32'h0);
    check({tag, " stall"}, 32'(stall), 32'h0);
    tick();
    check({tag, " mis pulse"}, 32'(mis), 32'h1);
    check({tag, " no valid"}, 32'(valid), 32'h0);
    check({tag, " result held"}, lu_out, held);
    idle_inputs();
    tick();
    check({tag, " mis one cycle"}, 32'(mis), 32'h0);
    check({tag, " no late valid"}, 32'(valid), 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    rdata = 32'h0;
    idle_inputs();
    // Reset: a request with HREADY low must neither stall nor start a transfer.
    req = 1'b1; funct3 = 3'b010; iadder = 32'h100; ready = 1'b0;
    tick();
    tick();
    check("reset htrans", 32'(htrans), 32'h0);
    check("reset stall", 32'(stall), 32'h0);
    check("reset result", lu_out, 32'h0);
    check("reset valid", 32'(valid), 32'h0);
    check("reset err", 32'(err), 32'h0);
    check("reset mis", 32'(mis), 32'h0);
    check("hsize word", 32'(hsize), 32'h2);
    funct3 = 3'b000;
    #1;
    check("hsize byte", 32'(hsize), 32'h0);
    funct3 = 3'b101;
    #1;
    check("hsize half", 32'(hsize), 32'h1);
    idle_inputs();
    rst = 1'b0;
    tick();

    // Lane extraction from 0x80AA55CC.
    do_load("lb 103",  3'b000, 32'h0000_0103, 32'h80AA55CC, 0, 32'hFFFFFF80);
    do_load("lhu 102", 3'b101, 32'h0000_0102, 32'h80AA55CC, 0, 32'h000080AA);
    do_load("lh 100",  3'b001, 32'h0000_0100, 32'h80AA55CC, 0, 32'h000055CC);
    do_load("lbu 101", 3'b100, 32'h0000_0101, 32'h80AA55CC, 0, 32'h00000055);
    do_load("lh 102",  3'b001, 32'h0000_0102, 32'h80AA55CC, 0, 32'hFFFF80AA);
    do_load("lb 101",  3'b000, 32'h0000_0101, 32'h80AA55CC, 0, 32'h00000055);
    do_load("und 110", 3'b110, 32'h0000_0100, 32'h80AA55CC, 0, 32'h80AA55CC);
    // Word load with two wait states.
    do_load("lw wait", 3'b010, 32'h0000_0200, 32'hDEADBEEF, 2, 32'hDEADBEEF);

    // Misaligned halfword and word.
    do_misaligned("mis lh 101", 3'b001, 32'h0000_0101, 32'hDEADBEEF);
    do_misaligned("mis lw 102", 3'b010, 32'h0000_0102, 32'hDEADBEEF);

    // Back-to-back: second address phase overlaps the first data phase.
    req = 1'b1; funct3 = 3'b010; iadder = 32'h100; ready = 1'b1;
    #1;
    check("pipe a0 htrans", 32'(htrans), 32'h2);
    tick();
    funct3 = 3'b100; iadder = 32'h105; rdata = 32'h11223344;
    #1;
    check("pipe a1 htrans", 32'(htrans), 32'h2);
    check("pipe a1 haddr", haddr, 32'h104);
    tick();
    check("pipe r0 valid", 32'(valid), 32'h1);
    check("pipe r0 result", lu_out, 32'h11223344);
    req = 1'b0; rdata = 32'h0000AB00;
    #1;
    check("pipe d1 htrans", 32'(htrans), 32'h0);
    tick();
    check("pipe r1 valid", 32'(valid), 32'h1);
    check("pipe r1 result", lu_out, 32'h000000AB);
    idle_inputs();
    tick();
    check("pipe done valid", 32'(valid), 32'h0);

    // Error response: error pulse, no valid, result held.
    req = 1'b1; funct3 = 3'b010; iadder = 32'h300; ready = 1'b1;
    tick();
    req = 1'b0; resp = 1'b1; rdata = 32'hCAFEF00D;
    tick();
    check("err pulse", 32'(err), 32'h1);
    check("err no valid", 32'(valid), 32'h0);
    check("err result held", lu_out, 32'h000000AB);
    resp = 1'b0;
    tick();
    check("err one cycle", 32'(err), 32'h0);
    check("err back idle", 32'(stall), 32'h0);

    // Reset during a wait state abandons the transfer.
    req = 1'b1; funct3 = 3'b010; iadder = 32'h400; ready = 1'b1;
    tick();
    req = 1'b0; ready = 1'b0;
    #1;
    check("rst wait stall", 32'(stall), 32'h1);
    rst = 1'b1;
    #1;
    check("rst stall low", 32'(stall), 32'h0);
    tick();
    req = 1'b1; ready = 1'b1;
    #1;
    check("rst htrans", 32'(htrans), 32'h0);
    req = 1'b0;
    tick();
    rst = 1'b0; ready = 1'b1; rdata = 32'h12345678;
    tick();
    check("post rst valid", 32'(valid), 32'h0);
    check("post rst err", 32'(err), 32'h0);
    check("post rst result", lu_out, 32'h0);
    ready = 1'b0;
    #1;
    check("post rst idle", 32'(stall), 32'h0);
    tick();
    check("post rst no pulse", 32'({valid, err, mis}), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
